// File: rtl/sy_axi_pkg.sv
// Shared AXI types for the core-side and crossbar-side ports.
// Crossbar IDs carry the originating master index in their MSBs.
package sy_axi;

    localparam int unsigned NrSlaves    = 2;
    localparam int unsigned IdWidth     = 4;
    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned MstIdxWidth = $clog2(NrSlaves);
    localparam int unsigned IdSlvWidth  = IdWidth + MstIdxWidth;

    typedef logic [IdWidth-1:0]     id_t;
    typedef logic [IdSlvWidth-1:0]  id_slv_t;
    typedef logic [AddrWidth-1:0]   addr_t;
    typedef logic [DataWidth-1:0]   data_t;
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef logic [7:0]             len_t;
    typedef logic [1:0]             axi_resp_t;
    typedef logic [MstIdxWidth-1:0] mst_idx_t;

    typedef struct packed {
        id_t   id;
        addr_t addr;
        len_t  len;
    } ax_t;

    typedef struct packed {
        id_slv_t id;
        addr_t   addr;
        len_t    len;
    } ax_slv_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_t;

    typedef struct packed {
        id_t       id;
        data_t     data;
        axi_resp_t resp;
        logic      last;
    } r_t;

    typedef struct packed {
        id_slv_t   id;
        data_t     data;
        axi_resp_t resp;
        logic      last;
    } r_slv_t;

    typedef struct packed {
        id_t       id;
        axi_resp_t resp;
    } b_t;

    typedef struct packed {
        id_slv_t   id;
        axi_resp_t resp;
    } b_slv_t;

    typedef struct packed {
        logic aw_valid;
        ax_t  aw;
        logic w_valid;
        w_t   w;
        logic b_ready;
        logic ar_valid;
        ax_t  ar;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        b_t   b;
        logic r_valid;
        r_t   r;
    } resp_t;

    typedef struct packed {
        logic    aw_valid;
        ax_slv_t aw;
        logic    w_valid;
        w_t      w;
        logic    b_ready;
        logic    ar_valid;
        ax_slv_t ar;
        logic    r_ready;
    } req_slv_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        b_slv_t b;
        logic   r_valid;
        r_slv_t r;
    } resp_slv_t;

endpackage

// File: rtl/sy_axi_rr_arb.sv
// Round-robin arbiter that holds its grant until the handshake completes.
module sy_axi_rr_arb #(
    parameter  int unsigned NrReq    = 2,
    localparam int unsigned IdxWidth = $clog2(NrReq)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NrReq-1:0]    req,
    input  logic                hs_ready,
    output logic                gnt_valid,
    output logic [IdxWidth-1:0] gnt_idx
);

    typedef logic [IdxWidth-1:0] idx_t;

    idx_t ptr;
    idx_t lock_idx;
    logic lock;

    always_comb begin
        gnt_valid = lock;
        gnt_idx   = lock_idx;
        if (!lock) begin
            for (int unsigned i = 0; i < NrReq; i++) begin
                if (!gnt_valid && req[(32'(ptr) + i) % NrReq]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = idx_t'((32'(ptr) + i) % NrReq);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (gnt_valid && hs_ready) begin
            lock <= 1'b0;
            ptr  <= idx_t'((32'(gnt_idx) + 1) % NrReq);
        end else if (gnt_valid) begin
            lock     <= 1'b1;
            lock_idx <= gnt_idx;
        end
    end

endmodule

// File: rtl/sy_axi_mux.sv
// Merges the core AXI masters onto one crossbar port; the master
// index travels in the ID MSBs and W follows AW grant order.
module sy_axi_mux
    import sy_axi::*;
#(
    parameter int unsigned MaxWTrans = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  req_t      mst_req_i  [NrSlaves],
    output resp_t     mst_resp_o [NrSlaves],
    output req_slv_t  slv_req_o,
    input  resp_slv_t slv_resp_i
);

    localparam int unsigned NrMst    = NrSlaves;
    localparam int unsigned PtrWidth = $clog2(MaxWTrans);

    typedef logic [PtrWidth-1:0] wptr_t;
    typedef logic [PtrWidth:0]   wcnt_t;

    logic [NrMst-1:0] ar_req;
    logic [NrMst-1:0] aw_req;
    logic             ar_gnt;
    logic             aw_gnt;
    mst_idx_t         ar_idx;
    mst_idx_t         aw_idx;

    mst_idx_t w_fifo [MaxWTrans];
    wptr_t    w_wr;
    wptr_t    w_rd;
    wcnt_t    w_cnt;
    logic     w_full;
    logic     w_push;
    logic     w_pop;
    mst_idx_t w_head;
    mst_idx_t r_idx;
    mst_idx_t b_idx;

    assign w_full = (w_cnt == wcnt_t'(MaxWTrans));
    assign w_head = w_fifo[w_rd];
    assign r_idx  = slv_resp_i.r.id[IdSlvWidth-1 -: MstIdxWidth];
    assign b_idx  = slv_resp_i.b.id[IdSlvWidth-1 -: MstIdxWidth];
    assign w_push = slv_req_o.aw_valid && slv_resp_i.aw_ready;
    assign w_pop  = slv_req_o.w_valid && slv_resp_i.w_ready
                 && slv_req_o.w.last;

    // A full route FIFO only blocks new AW arbitration, never a held grant.
    always_comb begin
        for (int unsigned i = 0; i < NrMst; i++) begin
            ar_req[i] = mst_req_i[i].ar_valid;
            aw_req[i] = mst_req_i[i].aw_valid && !w_full;
        end
    end

    sy_axi_rr_arb #(.NrReq(NrMst)) u_ar_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (ar_req),
        .hs_ready (slv_resp_i.ar_ready),
        .gnt_valid(ar_gnt),
        .gnt_idx  (ar_idx)
    );

    sy_axi_rr_arb #(.NrReq(NrMst)) u_aw_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req      (aw_req),
        .hs_ready (slv_resp_i.aw_ready),
        .gnt_valid(aw_gnt),
        .gnt_idx  (aw_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_wr  <= '0;
            w_rd  <= '0;
            w_cnt <= '0;
            for (int unsigned i = 0; i < MaxWTrans; i++) w_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                w_fifo[w_wr] <= aw_idx;
                w_wr         <= w_wr + wptr_t'(1);
            end
            if (w_pop) w_rd <= w_rd + wptr_t'(1);
            if (w_push && !w_pop)      w_cnt <= w_cnt + wcnt_t'(1);
            else if (!w_push && w_pop) w_cnt <= w_cnt - wcnt_t'(1);
        end
    end

    always_comb begin
        slv_req_o = '0;
        for (int unsigned i = 0; i < NrMst; i++) mst_resp_o[i] = '0;
        if (!rst_i) begin
            slv_req_o.ar_valid = ar_gnt;
            slv_req_o.ar.id    = {ar_idx, mst_req_i[ar_idx].ar.id};
            slv_req_o.ar.addr  = mst_req_i[ar_idx].ar.addr;
            slv_req_o.ar.len   = mst_req_i[ar_idx].ar.len;
            mst_resp_o[ar_idx].ar_ready = ar_gnt && slv_resp_i.ar_ready;

            slv_req_o.aw_valid = aw_gnt;
            slv_req_o.aw.id    = {aw_idx, mst_req_i[aw_idx].aw.id};
            slv_req_o.aw.addr  = mst_req_i[aw_idx].aw.addr;
            slv_req_o.aw.len   = mst_req_i[aw_idx].aw.len;
            mst_resp_o[aw_idx].aw_ready = aw_gnt && slv_resp_i.aw_ready;

            if (w_cnt != '0) begin
                slv_req_o.w_valid = mst_req_i[w_head].w_valid;
                slv_req_o.w       = mst_req_i[w_head].w;
                mst_resp_o[w_head].w_ready = slv_resp_i.w_ready;
            end

            if (32'(r_idx) < NrMst) begin
                mst_resp_o[r_idx].r_valid = slv_resp_i.r_valid;
                mst_resp_o[r_idx].r.id    = slv_resp_i.r.id[IdWidth-1:0];
                mst_resp_o[r_idx].r.data  = slv_resp_i.r.data;
                mst_resp_o[r_idx].r.resp  = slv_resp_i.r.resp;
                mst_resp_o[r_idx].r.last  = slv_resp_i.r.last;
                slv_req_o.r_ready = mst_req_i[r_idx].r_ready;
            end else begin
                slv_req_o.r_ready = 1'b1;
            end

            if (32'(b_idx) < NrMst) begin
                mst_resp_o[b_idx].b_valid = slv_resp_i.b_valid;
                mst_resp_o[b_idx].b.id    = slv_resp_i.b.id[IdWidth-1:0];
                mst_resp_o[b_idx].b.resp  = slv_resp_i.b.resp;
                slv_req_o.b_ready = mst_req_i[b_idx].b_ready;
            end else begin
                slv_req_o.b_ready = 1'b1;
            end
        end
    end

    a_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_pop && w_cnt == '0));
    a_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full));
    a_ar_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        slv_req_o.ar_valid && !slv_resp_i.ar_ready |=> slv_req_o.ar_valid);
    a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        slv_req_o.aw_valid && !slv_resp_i.aw_ready |=> slv_req_o.aw_valid);
    a_r_idx: assert property (@(posedge clk_i) disable iff (rst_i)
        !(slv_resp_i.r_valid && 32'(r_idx) >= NrMst));
    a_b_idx: assert property (@(posedge clk_i) disable iff (rst_i)
        !(slv_resp_i.b_valid && 32'(b_idx) >= NrMst));

endmodule

// File: tb/tb_sy_axi_mux.sv
// Bench for sy_axi_mux: directed stimulus, queue-based scoreboard
// monitor on every handshake, plus in-line checks of stall/gating cycles.
module tb_sy_axi_mux;
    import sy_axi::*;

    logic      clk = 1'b0;
    logic      rst;
    req_t      mst_req  [NrSlaves];
    resp_t     mst_resp [NrSlaves];
    req_slv_t  slv_req;
    resp_slv_t slv_resp;

    req_t m_in [NrSlaves];
    logic wv   [NrSlaves];
    w_t   wd   [NrSlaves];
    logic w_hs [NrSlaves];
    w_t   wq   [NrSlaves][$];

    ax_slv_t exp_ar [$];
    ax_slv_t exp_aw [$];
    w_t      exp_w  [$];
    r_t      exp_r  [NrSlaves][$];
    b_t      exp_b  [NrSlaves][$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NrSlaves; i++) begin
            mst_req[i]         = m_in[i];
            mst_req[i].w_valid = wv[i];
            mst_req[i].w       = wd[i];
        end
    end

    sy_axi_mux #(.MaxWTrans(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .mst_req_i (mst_req),
        .mst_resp_o(mst_resp),
        .slv_req_o (slv_req),
        .slv_resp_i(slv_resp)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(string name, logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h expected no transfer", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ax_t mx(logic [3:0] id, logic [31:0] a, logic [7:0] l);
        ax_t x;
        x.id = id; x.addr = a; x.len = l;
        return x;
    endfunction

    function automatic ax_slv_t sx(logic [4:0] id, logic [31:0] a, logic [7:0] l);
        ax_slv_t x;
        x.id = id; x.addr = a; x.len = l;
        return x;
    endfunction

    function automatic w_t mw(logic [31:0] d, logic last);
        w_t x;
        x.data = d; x.strb = '1; x.last = last;
        return x;
    endfunction

    // W driver: presents queued beats, advances on handshake
    initial begin
        for (int i = 0; i < NrSlaves; i++) begin
            wv[i] = 1'b0;
            wd[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NrSlaves; i++)
                w_hs[i] = wv[i] && mst_resp[i].w_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NrSlaves; i++) begin
                if (w_hs[i] && wq[i].size() != 0) void'(wq[i].pop_front());
                wv[i] = (wq[i].size() != 0);
                if (wv[i]) wd[i] = wq[i][0];
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (slv_req.ar_valid && slv_resp.ar_ready) begin
                    if (exp_ar.size() == 0) unexp("ar_hs", 64'(slv_req.ar));
                    else chk("ar_hs", 64'(slv_req.ar), 64'(exp_ar.pop_front()));
                end
                if (slv_req.aw_valid && slv_resp.aw_ready) begin
                    if (exp_aw.size() == 0) unexp("aw_hs", 64'(slv_req.aw));
                    else chk("aw_hs", 64'(slv_req.aw), 64'(exp_aw.pop_front()));
                end
                if (slv_req.w_valid && slv_resp.w_ready) begin
                    if (exp_w.size() == 0) unexp("w_hs", 64'(slv_req.w));
                    else chk("w_hs", 64'(slv_req.w), 64'(exp_w.pop_front()));
                end
                for (int i = 0; i < NrSlaves; i++) begin
                    if (mst_resp[i].r_valid && mst_req[i].r_ready) begin
                        if (exp_r[i].size() == 0) unexp("r_hs", 64'(mst_resp[i].r));
                        else chk("r_hs", 64'(mst_resp[i].r), 64'(exp_r[i].pop_front()));
                    end
                    if (mst_resp[i].b_valid && mst_req[i].b_ready) begin
                        if (exp_b[i].size() == 0) unexp("b_hs", 64'(mst_resp[i].b));
                        else chk("b_hs", 64'(mst_resp[i].b), 64'(exp_b[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        r_t er;
        b_t eb;

        rst = 1'b1;
        for (int i = 0; i < NrSlaves; i++) m_in[i] = '0;
        slv_resp = '0;
        m_in[0].ar_valid = 1'b1;
        m_in[0].ar = mx(4'h3, 32'h1000, 8'd0);
        slv_resp.ar_ready = 1'b1;
        @(negedge clk);
        chk("rst_ar_valid", 64'(slv_req.ar_valid), 0);
        chk("rst_aw_valid", 64'(slv_req.aw_valid), 0);
        chk("rst_w_valid", 64'(slv_req.w_valid), 0);
        chk("rst_m0_ar_ready", 64'(mst_resp[0].ar_ready), 0);
        tick();
        rst = 1'b0;

        // AR: both masters same cycle
        m_in[1].ar_valid = 1'b1;
        m_in[1].ar = mx(4'h5, 32'h1100, 8'd0);
        exp_ar.push_back(sx(5'h03, 32'h1000, 8'd0));
        exp_ar.push_back(sx(5'h15, 32'h1100, 8'd0));
        @(negedge clk);
        chk("ar_c0_m0_ready", 64'(mst_resp[0].ar_ready), 1);
        chk("ar_c0_m1_ready", 64'(mst_resp[1].ar_ready), 0);
        tick();
        m_in[0].ar_valid = 1'b0;
        @(negedge clk);
        chk("ar_c1_m1_ready", 64'(mst_resp[1].ar_ready), 1);
        chk("ar_c1_id", 64'(slv_req.ar.id), 5'h15);
        tick();
        m_in[1].ar_valid = 1'b0;
        slv_resp.ar_ready = 1'b0;

        // AR: stalled m1 grant stays locked while m0 requests
        m_in[1].ar_valid = 1'b1;
        m_in[1].ar = mx(4'hA, 32'h1200, 8'd2);
        exp_ar.push_back(sx(5'h1A, 32'h1200, 8'd2));
        @(negedge clk);
        chk("ar_stall_valid", 64'(slv_req.ar_valid), 1);
        tick();
        m_in[0].ar_valid = 1'b1;
        m_in[0].ar = mx(4'h1, 32'h1300, 8'd0);
        exp_ar.push_back(sx(5'h01, 32'h1300, 8'd0));
        @(negedge clk);
        chk("ar_lock_id", 64'(slv_req.ar.id), 5'h1A);
        chk("ar_lock_m0_ready", 64'(mst_resp[0].ar_ready), 0);
        tick();
        @(negedge clk);
        chk("ar_lock_id2", 64'(slv_req.ar.id), 5'h1A);
        chk("ar_lock_addr", 64'(slv_req.ar.addr), 32'h1200);
        tick();
        slv_resp.ar_ready = 1'b1;
        @(negedge clk);
        chk("ar_lock_m1_ready", 64'(mst_resp[1].ar_ready), 1);
        tick();
        m_in[1].ar_valid = 1'b0;
        @(negedge clk);
        chk("ar_after_m0_ready", 64'(mst_resp[0].ar_ready), 1);
        tick();
        m_in[0].ar_valid = 1'b0;
        slv_resp.ar_ready = 1'b0;

        // AW/W ordering: m0 4-beat burst then m1 single beat
        slv_resp.aw_ready = 1'b1;
        slv_resp.w_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wq[0].push_back(mw(32'h100 + k, k == 3));
            exp_w.push_back(mw(32'h100 + k, k == 3));
        end
        wq[1].push_back(mw(32'h200, 1'b1));
        exp_w.push_back(mw(32'h200, 1'b1));
        m_in[0].aw_valid = 1'b1;
        m_in[0].aw = mx(4'h2, 32'h2000, 8'd3);
        m_in[1].aw_valid = 1'b1;
        m_in[1].aw = mx(4'h7, 32'h3000, 8'd0);
        exp_aw.push_back(sx(5'h02, 32'h2000, 8'd3));
        exp_aw.push_back(sx(5'h17, 32'h3000, 8'd0));
        @(negedge clk);
        chk("w_before_aw", 64'(slv_req.w_valid), 0);
        chk("aw_c0_m0_ready", 64'(mst_resp[0].aw_ready), 1);
        chk("aw_c0_m1_ready", 64'(mst_resp[1].aw_ready), 0);
        tick();
        m_in[0].aw_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w_m1_held", 64'(mst_resp[1].w_ready), 0);
            tick();
            if (k == 0) m_in[1].aw_valid = 1'b0;
        end
        @(negedge clk);
        chk("w_m1_ready", 64'(mst_resp[1].w_ready), 1);
        chk("w_m1_data", 64'(slv_req.w.data), 32'h200);
        tick();

        // FIFO full: fifth AW blocked until a W last completes
        slv_resp.w_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wq[0].push_back(mw(32'h300 + k, 1'b1));
            exp_w.push_back(mw(32'h300 + k, 1'b1));
            exp_aw.push_back(sx({1'b0, 4'(k)}, 32'h4000 + 32'(16 * k), 8'd0));
        end
        m_in[0].aw_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_in[0].aw = mx(4'(k), 32'h4000 + 32'(16 * k), 8'd0);
            @(negedge clk);
            chk("aw_fill_ready", 64'(mst_resp[0].aw_ready), 1);
            tick();
        end
        m_in[0].aw = mx(4'h4, 32'h4040, 8'd0);
        @(negedge clk);
        chk("aw_full_valid", 64'(slv_req.aw_valid), 0);
        chk("aw_full_ready", 64'(mst_resp[0].aw_ready), 0);
        tick();
        slv_resp.w_ready = 1'b1;
        @(negedge clk);
        chk("aw_full_pop_cycle", 64'(slv_req.aw_valid), 0);
        chk("w_full_valid", 64'(slv_req.w_valid), 1);
        tick();
        @(negedge clk);
        chk("aw_after_pop", 64'(slv_req.aw_valid), 1);
        tick();
        m_in[0].aw_valid = 1'b0;
        repeat (6) tick();

        // R and B routing with backpressure
        slv_resp.r_valid = 1'b1;
        slv_resp.r.id    = 5'h13;
        slv_resp.r.data  = 32'hCAFE0001;
        slv_resp.r.resp  = 2'b00;
        slv_resp.r.last  = 1'b1;
        er.id = 4'h3; er.data = 32'hCAFE0001; er.resp = 2'b00; er.last = 1'b1;
        exp_r[1].push_back(er);
        @(negedge clk);
        chk("r_m1_valid", 64'(mst_resp[1].r_valid), 1);
        chk("r_m0_valid", 64'(mst_resp[0].r_valid), 0);
        chk("r_m1_id", 64'(mst_resp[1].r.id), 4'h3);
        chk("r_bp_ready", 64'(slv_req.r_ready), 0);
        tick();
        m_in[1].r_ready = 1'b1;
        @(negedge clk);
        chk("r_ready", 64'(slv_req.r_ready), 1);
        tick();
        slv_resp.r_valid = 1'b0;
        m_in[1].r_ready  = 1'b0;
        slv_resp.b_valid = 1'b1;
        slv_resp.b.id    = 5'h05;
        slv_resp.b.resp  = 2'b01;
        m_in[0].b_ready  = 1'b1;
        eb.id = 4'h5; eb.resp = 2'b01;
        exp_b[0].push_back(eb);
        @(negedge clk);
        chk("b_m1_valid", 64'(mst_resp[1].b_valid), 0);
        chk("b_m0_id", 64'(mst_resp[0].b.id), 4'h5);
        chk("b_ready", 64'(slv_req.b_ready), 1);
        tick();
        slv_resp.b_valid = 1'b0;
        m_in[0].b_ready  = 1'b0;

        // Reset with two W routes pending and AR locked on m1
        slv_resp.w_ready  = 1'b0;
        slv_resp.ar_ready = 1'b0;
        wq[0].push_back(mw(32'h999, 1'b1));
        m_in[0].aw_valid = 1'b1;
        m_in[0].aw = mx(4'h8, 32'h5000, 8'd0);
        m_in[1].ar_valid = 1'b1;
        m_in[1].ar = mx(4'h7, 32'h6000, 8'd0);
        exp_aw.push_back(sx(5'h08, 32'h5000, 8'd0));
        exp_aw.push_back(sx(5'h09, 32'h5010, 8'd0));
        tick();
        m_in[0].aw = mx(4'h9, 32'h5010, 8'd0);
        @(negedge clk);
        chk("pre_rst_ar_id", 64'(slv_req.ar.id), 5'h17);
        tick();
        rst = 1'b1;
        m_in[0].ar_valid = 1'b1;
        m_in[0].ar = mx(4'h2, 32'h7000, 8'd0);
        @(negedge clk);
        chk("mid_rst_ar_valid", 64'(slv_req.ar_valid), 0);
        chk("mid_rst_aw_valid", 64'(slv_req.aw_valid), 0);
        chk("mid_rst_w_valid", 64'(slv_req.w_valid), 0);
        chk("mid_rst_m0_aw_ready", 64'(mst_resp[0].aw_ready), 0);
        tick();
        rst = 1'b0;
        m_in[0].aw_valid  = 1'b0;
        slv_resp.ar_ready = 1'b1;
        exp_ar.push_back(sx(5'h02, 32'h7000, 8'd0));
        exp_ar.push_back(sx(5'h17, 32'h6000, 8'd0));
        @(negedge clk);
        chk("post_rst_ar_id", 64'(slv_req.ar.id), 5'h02);
        chk("post_rst_w_valid", 64'(slv_req.w_valid), 0);
        tick();
        m_in[0].ar_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_m1_ready", 64'(mst_resp[1].ar_ready), 1);
        tick();
        m_in[1].ar_valid  = 1'b0;
        slv_resp.ar_ready = 1'b0;
        wq[0].delete();
        repeat (3) tick();

        chk("ar_left", 64'(exp_ar.size()), 0);
        chk("aw_left", 64'(exp_aw.size()), 0);
        chk("w_left", 64'(exp_w.size()), 0);
        chk("r1_left", 64'(exp_r[1].size()), 0);
        chk("b0_left", 64'(exp_b[0].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
